// File: rtl/tart_sampler_pkg.sv
// tart_sampler_pkg
// Shared definitions for the antenna phase sampler and its calibration
// histogram: the fixed fast-to-sample clock ratio, the phase index type,
// the calibration state encoding and two small phase helper functions.
package tart_sampler_pkg;

    // fast_clk cycles per sample period; phase indices run 0..RATIO-1
    localparam int RATIO = 6;

    typedef logic [2:0] phase_t;

    localparam phase_t LAST_PHASE = phase_t'(RATIO - 1);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        COUNT,
        PICK
    } cal_state_t;

    // Out-of-range phase requests (6, 7) fall back to the last valid phase
    function automatic phase_t clamp_phase(input logic [2:0] requested);
        return (requested > LAST_PHASE) ? LAST_PHASE : requested;
    endfunction

    // The phase half a sample period away from e, i.e. (e + 3) mod 6
    function automatic phase_t opposite_phase(input phase_t e);
        return (e >= 3'd3) ? (e - 3'd3) : (e + 3'd3);
    endfunction

endpackage

// File: rtl/phase_edge_histogram.sv
// phase_edge_histogram
// Six saturating counters, one per sample phase, that count data
// transitions seen on the calibration antenna, plus a combinational
// argmax over them.
//
// Ports:
//   fast_clk   in   clock
//   rst        in   synchronous active-high reset
//   clear      in   zero all counters this cycle
//   count_en   in   accumulate transitions this cycle
//   edge_seen  in   calibration antenna changed this cycle
//   ph         in   current phase index
//   best       out  index of the largest counter (lowest index on ties)
//   any_edges  out  at least one counter is non-zero
module phase_edge_histogram
    import tart_sampler_pkg::*;
#(
    parameter int CNT_W = 12
) (
    input  logic   fast_clk,
    input  logic   rst,
    input  logic   clear,
    input  logic   count_en,
    input  logic   edge_seen,
    input  phase_t ph,
    output phase_t best,
    output logic   any_edges
);

    logic [CNT_W-1:0] h [RATIO];
    logic [CNT_W-1:0] best_cnt;

    always_ff @(posedge fast_clk) begin
        if (rst || clear) begin
            for (int i = 0; i < RATIO; i++) begin
                h[i] <= '0;
            end
        end else if (count_en && edge_seen) begin
            for (int i = 0; i < RATIO; i++) begin
                // Counters stick at all-ones instead of wrapping
                if (ph == phase_t'(i) && h[i] != {CNT_W{1'b1}}) begin
                    h[i] <= h[i] + 1'b1;
                end
            end
        end
    end

    // Strict greater-than keeps the lowest index when counts tie
    always_comb begin
        best_cnt = h[0];
        best     = '0;
        for (int i = 1; i < RATIO; i++) begin
            if (h[i] > best_cnt) begin
                best_cnt = h[i];
                best     = phase_t'(i);
            end
        end
        any_edges = (best_cnt != '0);
    end

endmodule

// File: rtl/antenna_phase_sampler.sv
// antenna_phase_sampler
// Samples raw 1-bit antenna streams inside the fast_clk domain. A free-running
// 0..5 phase counter replaces the slow sampling clock; one sample word is
// captured per period at the selected phase. The selected phase only changes
// at the end of a period, so every period carries exactly one strobe.
//
// Build option: define SAMPLER_CAL_EN to include the edge-histogram phase
// calibration. Without it cal_busy/cal_done read 0, cal_start/cal_ant are
// ignored and the phase comes only from data_sample_delay.
//
// Ports:
//   fast_clk           in   sole clock, 6x the sample rate
//   rst                in   synchronous active-high reset
//   antenna            in   raw asynchronous antenna bits
//   enable             in   sampling enable
//   data_sample_delay  in   manual phase select 0..5 (6, 7 clamp to 5)
//   cal_start          in   one-cycle calibration start pulse
//   cal_ant            in   calibration antenna index (out of range -> 0)
//   sample_data        out  captured sample word
//   sample_valid       out  one-cycle strobe when sample_data updates
//   phase_used         out  phase currently applied
//   cal_busy           out  calibration in progress
//   cal_done           out  sticky calibration-complete flag
module antenna_phase_sampler
    import tart_sampler_pkg::*;
#(
    parameter int ANTENNAS = 24,
    parameter int CAL_LOG2 = 10,
    parameter int CNT_W    = 12
) (
    input  logic                fast_clk,
    input  logic                rst,
    input  logic [ANTENNAS-1:0] antenna,
    input  logic                enable,
    input  logic [2:0]          data_sample_delay,
    input  logic                cal_start,
    input  logic [4:0]          cal_ant,
    output logic [ANTENNAS-1:0] sample_data,
    output logic                sample_valid,
    output logic [2:0]          phase_used,
    output logic                cal_busy,
    output logic                cal_done
);

    logic [ANTENNAS-1:0] sync_meta;
    logic [ANTENNAS-1:0] sync_s;
    phase_t              ph;
    phase_t              pending_phase;
    logic                capture;

    // Two-flop synchroniser on the raw antenna bits
    always_ff @(posedge fast_clk) begin
        if (rst) begin
            sync_meta <= '0;
            sync_s    <= '0;
        end else begin
            sync_meta <= antenna;
            sync_s    <= sync_meta;
        end
    end

    // Free-running phase counter, independent of enable
    always_ff @(posedge fast_clk) begin
        if (rst) begin
            ph <= '0;
        end else if (ph == LAST_PHASE) begin
            ph <= '0;
        end else begin
            ph <= ph + 3'd1;
        end
    end

    assign capture = enable && (ph == phase_used);

    // Capture the synchronised word at the selected phase; strobe follows
    always_ff @(posedge fast_clk) begin
        if (rst) begin
            sample_data  <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= capture;
            if (capture) begin
                sample_data <= sync_s;
            end
        end
    end

    // Loading only on the last phase keeps a phase change from producing
    // zero or two captures inside one period
    always_ff @(posedge fast_clk) begin
        if (rst) begin
            phase_used <= '0;
        end else if (ph == LAST_PHASE) begin
            phase_used <= pending_phase;
        end
    end

`ifdef SAMPLER_CAL_EN

    localparam int COUNT_CYCLES = RATIO * (2 ** CAL_LOG2);
    localparam int TIMER_W      = $clog2(COUNT_CYCLES);

    cal_state_t         state;
    cal_state_t         state_next;
    logic [TIMER_W-1:0] timer;
    logic               cal_bit;
    logic               cal_bit_prev;
    phase_t             cal_result;
    phase_t             hist_best;
    logic               hist_any;

    // Select the calibration antenna; out-of-range indices use antenna 0
    always_comb begin
        cal_bit = sync_s[0];
        for (int i = 0; i < ANTENNAS; i++) begin
            if (cal_ant == 5'(i)) begin
                cal_bit = sync_s[i];
            end
        end
    end

    always_ff @(posedge fast_clk) begin
        if (rst) begin
            cal_bit_prev <= 1'b0;
        end else begin
            cal_bit_prev <= cal_bit;
        end
    end

    // Calibration state register
    always_ff @(posedge fast_clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Calibration next state; a start pulse is only honoured from IDLE
    always_comb begin
        state_next = state;
        cal_busy   = (state != IDLE);
        case (state)
            IDLE:    if (cal_start) state_next = CLEAR;
            CLEAR:   state_next = COUNT;
            COUNT:   if (timer == TIMER_W'(COUNT_CYCLES - 1)) state_next = PICK;
            PICK:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Counts the fast_clk cycles spent in the histogram window
    always_ff @(posedge fast_clk) begin
        if (rst || state != COUNT) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    // Result register: the override drops as soon as a new run starts and
    // returns with the freshly picked phase at the end of PICK
    always_ff @(posedge fast_clk) begin
        if (rst) begin
            cal_result <= '0;
            cal_done   <= 1'b0;
        end else if (state == IDLE && cal_start) begin
            cal_done <= 1'b0;
        end else if (state == PICK) begin
            cal_done   <= 1'b1;
            cal_result <= hist_any ? opposite_phase(hist_best) : '0;
        end
    end

    assign pending_phase = cal_done ? cal_result : clamp_phase(data_sample_delay);

    phase_edge_histogram #(
        .CNT_W(CNT_W)
    ) u_hist (
        .fast_clk (fast_clk),
        .rst      (rst),
        .clear    (state == CLEAR),
        .count_en (state == COUNT),
        .edge_seen(cal_bit ^ cal_bit_prev),
        .ph       (ph),
        .best     (hist_best),
        .any_edges(hist_any)
    );

`else

    localparam int unused_cfg = CAL_LOG2 + CNT_W;

    logic unused_cal;

    assign unused_cal    = ^{cal_start, cal_ant};
    assign cal_busy      = 1'b0;
    assign cal_done      = 1'b0;
    assign pending_phase = clamp_phase(data_sample_delay);

`endif

endmodule

// File: tb/tb_antenna_phase_sampler.sv
// tb_antenna_phase_sampler
// Directed bench for antenna_phase_sampler. Cycle numbers count fast_clk
// edges after reset release; cycle n is the interval after edge n, so the
// DUT phase counter equals n mod 6 during cycle n. Outputs are sampled on
// the falling edge and inputs are changed right after sampling.
// The calibration section depends on SAMPLER_CAL_EN.
module tb_antenna_phase_sampler;

    logic        fast_clk = 1'b0;
    logic        rst;
    logic [23:0] antenna;
    logic        enable;
    logic [2:0]  data_sample_delay;
    logic        cal_start;
    logic [4:0]  cal_ant;
    logic [23:0] sample_data;
    logic        sample_valid;
    logic [2:0]  phase_used;
    logic        cal_busy;
    logic        cal_done;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    always #5 fast_clk = ~fast_clk;

    antenna_phase_sampler #(
        .ANTENNAS(24),
        .CAL_LOG2(4),
        .CNT_W   (12)
    ) dut (
        .fast_clk         (fast_clk),
        .rst              (rst),
        .antenna          (antenna),
        .enable           (enable),
        .data_sample_delay(data_sample_delay),
        .cal_start        (cal_start),
        .cal_ant          (cal_ant),
        .sample_data      (sample_data),
        .sample_valid     (sample_valid),
        .phase_used       (phase_used),
        .cal_busy         (cal_busy),
        .cal_done         (cal_done)
    );

    task automatic applyStimulus(input logic en, input logic [2:0] delay, input logic [23:0] ant);
        enable            = en;
        data_sample_delay = delay;
        antenna           = ant;
    endtask

    task automatic stepCycle();
        @(negedge fast_clk);
        cyc++;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h at cycle %0d", tag, observed, expected, cyc);
        end
    endtask

    // Hand-derived strobe cycles for the first sampling scenario
    function automatic logic expValid(input int n);
        case (n)
            1, 9, 15, 21, 27, 33, 37, 43, 49, 59, 65, 71, 77, 84, 90, 108, 114: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] expData(input int n);
        if (n <= 8)   return 32'h0;
        if (n <= 107) return 32'hA5A5A5;
        return 32'h123456;
    endfunction

    initial begin
        rst       = 1'b1;
        cal_start = 1'b0;
        cal_ant   = 5'd3;
        applyStimulus(1'b1, 3'd2, 24'hA5A5A5);
        repeat (4) @(negedge fast_clk);

        checkOutput("reset_valid", 32'(sample_valid), 32'h0);
        checkOutput("reset_data", 32'(sample_data), 32'h0);
        checkOutput("reset_phase", 32'(phase_used), 32'h0);
        checkOutput("reset_busy", 32'(cal_busy), 32'h0);
        checkOutput("reset_done", 32'(cal_done), 32'h0);

        rst = 1'b0;
        cyc = 0;

        // Sampling, phase changes at period end, clamp, enable gating
        for (int n = 1; n <= 114; n++) begin
            stepCycle();
            checkOutput("valid", 32'(sample_valid), 32'(expValid(cyc)));
            checkOutput("data", 32'(sample_data), expData(cyc));
            if (cyc == 5)  checkOutput("phase_before_load", 32'(phase_used), 32'd0);
            if (cyc == 6)  checkOutput("phase_delay2", 32'(phase_used), 32'd2);
            if (cyc == 53) checkOutput("phase_hold_mid", 32'(phase_used), 32'd0);
            if (cyc == 54) checkOutput("phase_delay4", 32'(phase_used), 32'd4);
            if (cyc == 77) checkOutput("phase_hold_4", 32'(phase_used), 32'd4);
            if (cyc == 78) checkOutput("phase_clamp7", 32'(phase_used), 32'd5);
            if (cyc == 30)  applyStimulus(1'b1, 3'd0, 24'hA5A5A5);
            if (cyc == 50)  applyStimulus(1'b1, 3'd4, 24'hA5A5A5);
            if (cyc == 72)  applyStimulus(1'b1, 3'd7, 24'hA5A5A5);
            if (cyc == 91)  applyStimulus(1'b0, 3'd7, 24'h123456);
            if (cyc == 103) applyStimulus(1'b1, 3'd7, 24'h123456);
        end

`ifdef SAMPLER_CAL_EN
        // Calibration with antenna 3 toggling so that the synchronised bit
        // changes during phase 1 cycles: expect result (1+3) mod 6 = 4
        applyStimulus(1'b1, 3'd2, 24'h000000);
        for (int n = 115; n <= 230; n++) begin
            stepCycle();
            checkOutput("cal1_busy", 32'(cal_busy), 32'(cyc >= 121 && cyc <= 218));
            checkOutput("cal1_done", 32'(cal_done), 32'(cyc >= 219));
            if (cyc == 119) checkOutput("cal1_phase_pre", 32'(phase_used), 32'd5);
            if (cyc == 120) checkOutput("cal1_phase_manual", 32'(phase_used), 32'd2);
            if (cyc == 221) checkOutput("cal1_phase_hold", 32'(phase_used), 32'd2);
            if (cyc == 222) checkOutput("cal1_phase_result", 32'(phase_used), 32'd4);
            if (cyc % 6 == 5 && cyc < 230) antenna[3] = ~antenna[3];
            if (cyc == 120 || cyc == 150) cal_start = 1'b1;
            if (cyc == 121 || cyc == 151) cal_start = 1'b0;
        end

        // Calibration on a constant antenna: no transitions, result 0
        for (int n = 231; n <= 340; n++) begin
            stepCycle();
            checkOutput("cal2_busy", 32'(cal_busy), 32'(cyc >= 235 && cyc <= 332));
            checkOutput("cal2_done", 32'(cal_done), 32'(cyc < 235 || cyc >= 333));
            if (cyc == 239) checkOutput("cal2_override_kept", 32'(phase_used), 32'd4);
            if (cyc == 240) checkOutput("cal2_override_cleared", 32'(phase_used), 32'd2);
            if (cyc == 335) checkOutput("cal2_phase_hold", 32'(phase_used), 32'd2);
            if (cyc == 336) checkOutput("cal2_phase_result", 32'(phase_used), 32'd0);
            if (cyc == 234 || cyc == 340) cal_start = 1'b1;
            if (cyc == 235) cal_start = 1'b0;
        end

        // Reset in the middle of the histogram window
        for (int n = 341; n <= 361; n++) begin
            stepCycle();
            if (cyc == 341) cal_start = 1'b0;
            if (cyc <= 360) begin
                checkOutput("cal3_busy", 32'(cal_busy), 32'h1);
                checkOutput("cal3_done", 32'(cal_done), 32'h0);
            end
            if (cyc == 347) checkOutput("cal3_phase_pre", 32'(phase_used), 32'd0);
            if (cyc == 348) checkOutput("cal3_phase_manual", 32'(phase_used), 32'd2);
            if (cyc == 361) begin
                checkOutput("rst_mid_busy", 32'(cal_busy), 32'h0);
                checkOutput("rst_mid_done", 32'(cal_done), 32'h0);
                checkOutput("rst_mid_phase", 32'(phase_used), 32'h0);
            end
            if (cyc == 360) rst = 1'b1;
        end
        rst = 1'b0;
`else
        // Without calibration the start pulse must have no effect
        applyStimulus(1'b1, 3'd2, 24'hA5A5A5);
        for (int n = 115; n <= 140; n++) begin
            stepCycle();
            checkOutput("nocal_busy", 32'(cal_busy), 32'h0);
            checkOutput("nocal_done", 32'(cal_done), 32'h0);
            checkOutput("nocal_valid", 32'(sample_valid),
                        32'(cyc == 120 || cyc == 123 || cyc == 129 || cyc == 135));
            if (cyc == 119) checkOutput("nocal_phase_pre", 32'(phase_used), 32'd5);
            if (cyc == 120) checkOutput("nocal_phase", 32'(phase_used), 32'd2);
            if (cyc == 120) cal_start = 1'b1;
            if (cyc == 121) cal_start = 1'b0;
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/antenna_phase_sampler.md
Name: antenna_phase_sampler

Overview:
- Consumes the 6-phase sampling timing produced by the delay_data_sampling_clk stage, entirely inside the fast_clk domain.
- Slow-clock edges are replaced by a one-in-six phase strobe, so there is no derived clock.
- Synchronises the raw 1-bit antenna streams and captures one sample word per slow period at the selected phase.
- Optionally runs an edge-histogram calibration to choose the phase furthest from the data transitions.
- Output feeds the correlator/acquisition buffers.

Parameters:
- ANTENNAS, 24, number of 1-bit antenna inputs.
- RATIO, 6, fast_clk cycles per sample period (fixed; phase index 0..5).
- CAL_LOG2, 10, calibration window is 2^CAL_LOG2 sample periods.
- CNT_W, 12, width of each histogram counter (saturating).

Ports:
- fast_clk  in  1  sole clock, 6x the sample rate.
- rst  in  1  synchronous, active-high reset.
- antenna  in  ANTENNAS  raw asynchronous antenna bits.
- enable  in  1  sampling enable.
- data_sample_delay  in  3  manual phase select 0..5.
- cal_start  in  1  one-cycle pulse that starts calibration.
- cal_ant  in  5  antenna index used for calibration.
- sample_data  out  ANTENNAS  captured sample word.
- sample_valid  out  1  one-cycle strobe when sample_data updates.
- phase_used  out  3  phase currently applied.
- cal_busy  out  1  calibration in progress.
- cal_done  out  1  sticky; set when calibration completes.

Behaviour:
- Reset values (fast_clk edge with rst=1):
  - sample_data=0, sample_valid=0, phase_used=0, cal_busy=0, cal_done=0.
  - Phase counter=0; synchroniser flops=0; histogram=0.
- Synchroniser:
  - Two flops on antenna; the synchronised vector is S.
  - Latency from the antenna pin to S is 2 cycles.
- Phase counter ph:
  - Counts 0..5 and wraps 5->0.
  - Free-runs regardless of enable.
- Capture:
  - On a cycle where ph==phase_used and enable=1: sample_data<=S.
  - sample_valid=1 on the following cycle only.
  - Exactly one strobe per 6 cycles while enabled.
  - enable=0: no strobe and sample_data is held.
- Phase update:
  - The pending phase is data_sample_delay clamped to 5 (6 and 7 map to 5), or the calibration result.
  - The pending phase is loaded into phase_used only on the cycle ph==5.
  - This guarantees no period has 0 or 2 strobes.
  - While cal_done=1, the calibration result overrides data_sample_delay.
  - A new cal_start clears the override at start.
- Calibration FSM: IDLE -> CLEAR -> COUNT -> PICK -> IDLE.
  - IDLE: cal_start=1 -> CLEAR. cal_start while cal_busy=1 is ignored.
  - CLEAR (1 cycle): zero the six counters h[0..5]; cal_busy=1; cal_done=0.
  - COUNT (RATIO*2^CAL_LOG2 cycles):
    - Each cycle, if S[cal_ant] != previous S[cal_ant], increment h[ph].
    - Counters saturate at 2^CNT_W-1.
    - cal_ant >= ANTENNAS selects antenna 0.
  - PICK (1 cycle):
    - e = index of max h; ties go to the lowest index.
    - Result = (e+3) mod 6.
    - If all h are 0 (no transitions), the result is 0.
    - cal_busy=0, cal_done=1.
    - The result is applied at the next ph==5.
- Sampling continues during calibration using the previous phase_used.
- rst at any point returns the FSM to IDLE and clears the result.

Optional Feature:
- SAMPLER_CAL_EN
- Defined: calibration FSM, histogram and override as specified.
- Undefined:
  - No FSM or counters.
  - cal_busy and cal_done tied to 0; cal_start and cal_ant ignored.
  - phase_used follows only the clamped data_sample_delay, applied at ph==5.

Decomposition:
- Shared package tart_sampler_pkg holds:
  - the RATIO constant;
  - the phase index type (3 bits);
  - the calibration state enum (IDLE, CLEAR, COUNT, PICK);
  - the clamp-phase and (e+3) mod 6 functions.
- One sub-module: phase_edge_histogram (six saturating counters plus the argmax), instantiated only under SAMPLER_CAL_EN.

Test Plan:
- Release rst, enable=1, delay=2, antenna pattern A5A5A5 held -> first sample_valid within 2+6+1 cycles; then exactly one strobe every 6 cycles; sample_data=A5A5A5.
- Delay changed 0->4 mid-period -> phase_used changes only at the ph==5 edge; strobe spacing across the change stays within 1..11 cycles, with no double strobe in a period.
- delay=7 -> phase_used=5.
- enable toggled 0 for 12 cycles -> no strobes and sample_data held; strobes resume at the selected phase.
- Calibration (macro defined), CAL_LOG2=4, antenna 3 driven with transitions aligned to ph=1 -> cal_busy high for 96+2 cycles; h[1]=16; cal_done=1; phase_used=4 after the next ph==5.
- Calibration with a constant antenna -> result 0.
- rst asserted mid-COUNT -> cal_busy=0, cal_done=0, phase_used=0 next cycle.
- Repeat the first scenario with the macro undefined -> identical sampling; cal_start pulse leaves cal_busy=0 and cal_done=0.
